// File: rtl/tube_pkg.sv
// rtl/tube_pkg.sv - seven-segment patterns and BCD-to-segment decode for the tube counter
package tube_pkg;

  typedef logic [6:0] seg_t;

  // GFEDCBA, active-low
  localparam seg_t SEG_0     = 7'b1000000;
  localparam seg_t SEG_1     = 7'b1111001;
  localparam seg_t SEG_2     = 7'b0100100;
  localparam seg_t SEG_3     = 7'b0110000;
  localparam seg_t SEG_4     = 7'b0011001;
  localparam seg_t SEG_5     = 7'b0010010;
  localparam seg_t SEG_6     = 7'b0000010;
  localparam seg_t SEG_7     = 7'b1111000;
  localparam seg_t SEG_8     = 7'b0000000;
  localparam seg_t SEG_9     = 7'b0010000;
  localparam seg_t SEG_BLANK = 7'b1111111;

  localparam logic [3:0] BCD_MAX = 4'd9;

  function automatic seg_t bcd_to_seg(input logic [3:0] i_bcd, input logic i_blank);
    seg_t w_seg;
    if (i_blank) begin
      w_seg = SEG_BLANK;
    end else begin
      case (i_bcd)
        4'd0:    w_seg = SEG_0;
        4'd1:    w_seg = SEG_1;
        4'd2:    w_seg = SEG_2;
        4'd3:    w_seg = SEG_3;
        4'd4:    w_seg = SEG_4;
        4'd5:    w_seg = SEG_5;
        4'd6:    w_seg = SEG_6;
        4'd7:    w_seg = SEG_7;
        4'd8:    w_seg = SEG_8;
        4'd9:    w_seg = SEG_9;
        default: w_seg = SEG_BLANK;
      endcase
    end
    return w_seg;
  endfunction

endpackage

// File: rtl/bcd_updown_digit.sv
// rtl/bcd_updown_digit.sv - one BCD up/down digit with load and ripple carry/borrow
module bcd_updown_digit
  import tube_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       i_load,
  input  logic [3:0] i_load_value,
  input  logic       i_enable,
  input  logic       i_down,
  input  logic       i_carry,
  output logic [3:0] o_digit,
  output logic       o_carry
);

  logic [3:0] r_digit;
  logic       w_at_limit;

  // limit is 9 counting up, 0 counting down; carry-out doubles as borrow-out
  assign w_at_limit = i_down ? (r_digit == 4'd0) : (r_digit == BCD_MAX);
  assign o_carry    = i_enable & i_carry & w_at_limit;
  assign o_digit    = r_digit;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_digit <= '0;
    end else if (i_load) begin
      r_digit <= (i_load_value > BCD_MAX) ? 4'd0 : i_load_value;
    end else if (i_enable && i_carry) begin
      if (i_down) begin
        r_digit <= w_at_limit ? BCD_MAX : r_digit - 4'd1;
      end else begin
        r_digit <= w_at_limit ? 4'd0 : r_digit + 4'd1;
      end
    end
  end

endmodule

// File: rtl/multi_digit_tube_counter.sv
// rtl/multi_digit_tube_counter.sv - BCD up/down counter driving a multiplexed seven-segment tube display
module multi_digit_tube_counter
  import tube_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int COUNT_DIV  = 50_000_000,
  parameter int SCAN_DIV   = 12_500,
  parameter int BLANK_LZ   = 0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    i_enable,
  input  logic                    i_down,
  input  logic                    i_load,
  input  logic [4*NUM_DIGITS-1:0] i_load_value,
  output logic [4*NUM_DIGITS-1:0] o_count,
  output logic                    o_wrap,
  output logic [NUM_DIGITS-1:0]   o_digit_sel,
  output logic [6:0]              o_digit_pins
);

  localparam int CW = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;
  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [CW-1:0] COUNT_LAST = CW'(COUNT_DIV - 1);
  localparam logic [SW-1:0] SCAN_LAST  = SW'(SCAN_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);

  logic [CW-1:0]         r_count_pre;
  logic [SW-1:0]         r_scan_pre;
  logic [IW-1:0]         r_scan_idx;
  logic                  r_wrap;
  logic [NUM_DIGITS-1:0] r_digit_sel;
  seg_t                  r_digit_pins;

  logic                  w_tick;
  logic                  w_scan_step;
  logic                  w_step;
  logic [NUM_DIGITS:0]   w_carry;
  logic [3:0]            w_digit [NUM_DIGITS];
  logic [NUM_DIGITS-1:0] w_zero_above;
  logic [3:0]            w_cur_digit;
  logic                  w_cur_blank;

  assign w_tick      = (r_count_pre == COUNT_LAST);
  assign w_scan_step = (r_scan_pre == SCAN_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count_pre <= '0;
    end else if (w_tick) begin
      r_count_pre <= '0;
    end else begin
      r_count_pre <= r_count_pre + CW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_scan_pre <= '0;
    end else if (w_scan_step) begin
      r_scan_pre <= '0;
    end else begin
      r_scan_pre <= r_scan_pre + SW'(1);
    end
  end

  // a load in the tick cycle suppresses the step and therefore any wrap
  assign w_step     = w_tick & i_enable & ~i_load;
  assign w_carry[0] = 1'b1;

  genvar k;
  generate
    for (k = 0; k < NUM_DIGITS; k++) begin : g_digit
      bcd_updown_digit u_digit (
        .clk          (clk),
        .reset        (reset),
        .i_load       (i_load),
        .i_load_value (i_load_value[4*k +: 4]),
        .i_enable     (w_step),
        .i_down       (i_down),
        .i_carry      (w_carry[k]),
        .o_digit      (w_digit[k]),
        .o_carry      (w_carry[k+1])
      );

      assign o_count[4*k +: 4] = w_digit[k];
      assign w_zero_above[k]   = (o_count[4*NUM_DIGITS-1:4*k] == '0);
    end
  endgenerate

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wrap <= 1'b0;
    end else begin
      r_wrap <= w_carry[NUM_DIGITS];
    end
  end

  assign o_wrap = r_wrap;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_scan_idx <= '0;
    end else if (w_scan_step) begin
      r_scan_idx <= (r_scan_idx == IDX_LAST) ? '0 : r_scan_idx + IW'(1);
    end
  end

  // the least significant digit always shows, even when the whole count is zero
  assign w_cur_digit = w_digit[r_scan_idx];
  assign w_cur_blank = (BLANK_LZ != 0) && (r_scan_idx != '0) && w_zero_above[r_scan_idx];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_digit_sel  <= '0;
      r_digit_pins <= SEG_BLANK;
    end else if (w_scan_step) begin
      r_digit_sel  <= NUM_DIGITS'(1) << r_scan_idx;
      r_digit_pins <= bcd_to_seg(w_cur_digit, w_cur_blank);
    end
  end

  assign o_digit_sel  = r_digit_sel;
  assign o_digit_pins = r_digit_pins;

endmodule

// File: tb/tb_multi_digit_tube_counter.sv
// tb/tb_multi_digit_tube_counter.sv - self-checking bench for the BCD tube counter
module tb_multi_digit_tube_counter;

  localparam logic [6:0] P_SEVEN = 7'b1111000;
  localparam logic [6:0] P_OFF   = 7'b1111111;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       i_enable;
  logic       i_down;
  logic       i_load;
  logic [7:0] i_load_value;
  logic [7:0] o_count;
  logic       o_wrap;
  logic [1:0] o_digit_sel;
  logic [6:0] o_digit_pins;

  typedef struct {
    logic [7:0] count;
    logic       wrap;
  } cnt_exp_t;

  typedef struct {
    logic [1:0] sel;
    logic [6:0] pins;
  } disp_exp_t;

  typedef struct {
    logic       en;
    logic       down;
    logic       load;
    logic [7:0] value;
    logic [7:0] exp_count;
    logic       exp_wrap;
  } vec_t;

  cnt_exp_t  sb_q[$];
  disp_exp_t disp_q[$];
  vec_t      vecs[12];

  int n_cmp = 0;
  int n_bad = 0;
  int edge_n = 0;

  multi_digit_tube_counter #(
    .NUM_DIGITS (2),
    .COUNT_DIV  (4),
    .SCAN_DIV   (2),
    .BLANK_LZ   (1)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .i_enable     (i_enable),
    .i_down       (i_down),
    .i_load       (i_load),
    .i_load_value (i_load_value),
    .o_count      (o_count),
    .o_wrap       (o_wrap),
    .o_digit_sel  (o_digit_sel),
    .o_digit_pins (o_digit_pins)
  );

  always #5 clk = ~clk;

  // clock edges since reset release, used to predict the scan phase
  always @(posedge clk) begin
    if (reset) edge_n <= 0;
    else       edge_n <= edge_n + 1;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, got %0d compared, want completion", n_cmp);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic next_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_tick();
    next_edge();
    check("wrap_width", {31'd0, o_wrap}, 32'd0);
    repeat (3) next_edge();
  endtask

  task automatic pop_count(input string name);
    cnt_exp_t e;
    if (sb_q.size() == 0) begin
      check({name, "_sb_empty"}, 32'd0, 32'd1);
    end else begin
      e = sb_q.pop_front();
      check({name, "_count"}, {24'd0, o_count}, {24'd0, e.count});
      check({name, "_wrap"}, {31'd0, o_wrap}, {31'd0, e.wrap});
    end
  endtask

  function automatic logic [7:0] to_bcd(input int n);
    logic [3:0] t;
    logic [3:0] o;
    t = 4'(n / 10);
    o = 4'(n % 10);
    return {t, o};
  endfunction

  // display state for count 0x07 seen just after edge n (n >= 2)
  function automatic disp_exp_t disp_at(input int n);
    disp_exp_t d;
    int slot;
    slot = n / 2 - 1;
    if ((slot % 2) == 0) begin
      d.sel  = 2'b01;
      d.pins = P_SEVEN;
    end else begin
      d.sel  = 2'b10;
      d.pins = P_OFF;
    end
    return d;
  endfunction

  initial begin
    cnt_exp_t  e;
    disp_exp_t d;

    vecs[0]  = '{1'b1, 1'b0, 1'b1, 8'h3C, 8'h30, 1'b0};
    vecs[1]  = '{1'b0, 1'b0, 1'b0, 8'h00, 8'h30, 1'b0};
    vecs[2]  = '{1'b0, 1'b1, 1'b0, 8'h00, 8'h30, 1'b0};
    vecs[3]  = '{1'b1, 1'b1, 1'b0, 8'h00, 8'h29, 1'b0};
    vecs[4]  = '{1'b1, 1'b0, 1'b0, 8'h00, 8'h30, 1'b0};
    vecs[5]  = '{1'b1, 1'b0, 1'b1, 8'hA5, 8'h05, 1'b0};
    vecs[6]  = '{1'b1, 1'b1, 1'b0, 8'h00, 8'h04, 1'b0};
    vecs[7]  = '{1'b1, 1'b1, 1'b1, 8'h00, 8'h00, 1'b0};
    vecs[8]  = '{1'b1, 1'b1, 1'b0, 8'h00, 8'h99, 1'b1};
    vecs[9]  = '{1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1};
    vecs[10] = '{1'b1, 1'b0, 1'b1, 8'hFF, 8'h00, 1'b0};
    vecs[11] = '{1'b0, 1'b0, 1'b1, 8'h9B, 8'h90, 1'b0};

    i_enable     = 1'b0;
    i_down       = 1'b0;
    i_load       = 1'b0;
    i_load_value = 8'h00;

    repeat (3) @(posedge clk);
    #1;
    check("rst_count", {24'd0, o_count}, 32'h00);
    check("rst_wrap", {31'd0, o_wrap}, 32'd0);
    check("rst_sel", {30'd0, o_digit_sel}, 32'd0);
    check("rst_pins", {25'd0, o_digit_pins}, {25'd0, P_OFF});
    reset    = 1'b0;
    i_enable = 1'b1;

    // count up through the full range and back to 00
    for (int i = 0; i < 100; i++) begin
      e.count = to_bcd((i + 1) % 100);
      e.wrap  = (i == 99);
      sb_q.push_back(e);
      wait_tick();
      pop_count("up");
    end

    // load 10 off-tick, then count down past 00
    i_down       = 1'b1;
    i_load       = 1'b1;
    i_load_value = 8'h10;
    next_edge();
    i_load = 1'b0;
    check("load10_count", {24'd0, o_count}, 32'h10);
    check("load10_wrap", {31'd0, o_wrap}, 32'd0);
    for (int i = 0; i < 11; i++) begin
      e.count = (i < 10) ? to_bcd(9 - i) : 8'h99;
      e.wrap  = (i == 10);
      sb_q.push_back(e);
      if (i == 0) repeat (3) next_edge();
      else        wait_tick();
      pop_count("down");
    end

    // one tick period per vector; loads land in the tick cycle
    for (int v = 0; v < 12; v++) begin
      i_enable = vecs[v].en;
      i_down   = vecs[v].down;
      e.count  = vecs[v].exp_count;
      e.wrap   = vecs[v].exp_wrap;
      sb_q.push_back(e);
      if (vecs[v].load) begin
        next_edge();
        check("vec_wrap_width", {31'd0, o_wrap}, 32'd0);
        repeat (2) next_edge();
        i_load       = 1'b1;
        i_load_value = vecs[v].value;
        next_edge();
        i_load = 1'b0;
      end else begin
        wait_tick();
      end
      pop_count($sformatf("vec%0d", v));
    end

    // leading-zero blanking while scanning 07
    i_enable     = 1'b0;
    i_load       = 1'b1;
    i_load_value = 8'h07;
    next_edge();
    i_load = 1'b0;
    check("load07_count", {24'd0, o_count}, 32'h07);
    repeat (3) next_edge();
    for (int c = 0; c < 8; c++) begin
      disp_q.push_back(disp_at(edge_n + 1));
      next_edge();
      d = disp_q.pop_front();
      check($sformatf("scan%0d_sel", c), {30'd0, o_digit_sel}, {30'd0, d.sel});
      check($sformatf("scan%0d_pins", c), {25'd0, o_digit_pins}, {25'd0, d.pins});
    end

    // short reset mid-count with a load pending
    i_load       = 1'b1;
    i_load_value = 8'h42;
    next_edge();
    i_load = 1'b0;
    check("load42_count", {24'd0, o_count}, 32'h42);
    next_edge();
    reset        = 1'b1;
    i_load       = 1'b1;
    i_load_value = 8'h99;
    #1;
    check("async_clear_count", {24'd0, o_count}, 32'h00);
    next_edge();
    check("mid_rst_count", {24'd0, o_count}, 32'h00);
    check("mid_rst_sel", {30'd0, o_digit_sel}, 32'd0);
    check("mid_rst_pins", {25'd0, o_digit_pins}, {25'd0, P_OFF});
    check("mid_rst_wrap", {31'd0, o_wrap}, 32'd0);
    reset    = 1'b0;
    i_load   = 1'b0;
    i_enable = 1'b1;
    i_down   = 1'b0;
    next_edge();
    check("post_rst_sel", {30'd0, o_digit_sel}, 32'd0);
    check("post_rst_pins", {25'd0, o_digit_pins}, {25'd0, P_OFF});
    check("post_rst_e1_count", {24'd0, o_count}, 32'h00);
    repeat (2) next_edge();
    check("post_rst_e3_count", {24'd0, o_count}, 32'h00);
    next_edge();
    check("post_rst_e4_count", {24'd0, o_count}, 32'h01);

    check("sb_drained", sb_q.size() + disp_q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
